// File: rtl/fetch_pkg.sv
// Shared encodings and constants for the instruction fetch stage.
// FETCH_MISALIGN_TRAP_EN adds the HALT state used for misaligned next-PC traps.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'b00,
        PCSEL_BR  = 2'b01,
        PCSEL_J   = 2'b10,
        PCSEL_JR  = 2'b11
    } pc_sel_e;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_RST   = 2'b00,
        ST_FETCH = 2'b01,
        ST_VALID = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        ST_RST   = 2'b00,
        ST_FETCH = 2'b01,
        ST_VALID = 2'b10
    } fetch_state_e;
`endif

    // Branch immediates count words, so the sign-extended field is scaled by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage (sequential, branch, jump, register).
// Only the low 26 instruction bits matter here, so only those are passed in.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [25:0]     instruction,
    input  logic [1:0]      pc_sel,
    input  logic            br_taken,
    input  logic [XLEN-1:0] rs_value,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc
);

    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel_e'(pc_sel))
            PCSEL_SEQ: next_pc = pc_plus4;
            PCSEL_BR:  if (br_taken) next_pc = pc_plus4 + branch_offset(instruction[15:0]);
            PCSEL_J:   next_pc = {pc_plus4[31:28], instruction, 2'b00};
            PCSEL_JR:  next_pc = rs_value;
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding req/ack memory fetch, hold-until-retire to the decoder.
// FETCH_MISALIGN_TRAP_EN adds the misalign output and a sticky HALT on misaligned targets.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      PC_MUX_Select,
    input  logic            br_taken,
    input  logic [XLEN-1:0] rs_value,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instruction,
    output logic            inst_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign
`endif
);

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] next_pc_raw;
    logic [XLEN-1:0] next_pc;

    next_pc_calc #(.XLEN(XLEN)) u_next_pc (
        .pc          (pc),
        .instruction (instruction[25:0]),
        .pc_sel      (PC_MUX_Select),
        .br_taken    (br_taken),
        .rs_value    (rs_value),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc_raw)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (next_pc_raw[1:0] != 2'b00);
    assign next_pc    = next_pc_raw;
`else
    // Without the trap, low address bits are silently dropped.
    assign next_pc = next_pc_raw & ~XLEN'(3);
`endif

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RST;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RST:   state_next = ST_FETCH;
            ST_FETCH: if (imem_ack) state_next = ST_VALID;
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_VALID: if (!stall) state_next = misaligned ? ST_HALT : ST_FETCH;
            ST_HALT:  state_next = ST_HALT;
`else
            ST_VALID: if (!stall) state_next = ST_FETCH;
`endif
            default:  state_next = ST_RST;
        endcase
    end

    always_comb begin
        imem_req   = (state == ST_FETCH);
        inst_valid = (state == ST_VALID);
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign   = (state == ST_HALT);
`endif
    end

    // Instruction captures on ack; PC advances only when the decoder retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instruction <= NOP_INSTR;
        end else begin
            if (state == ST_FETCH && imem_ack) instruction <= imem_rdata;
            if (state == ST_VALID && !stall)   pc          <= next_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: random memory latency/stalls/selects against a next-PC reference model.
// Builds with or without FETCH_MISALIGN_TRAP_EN.
module tb_inst_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PC_MUX_Select;
    logic        br_taken;
    logic [31:0] rs_value;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    inst_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_MUX_Select (PC_MUX_Select),
        .br_taken      (br_taken),
        .rs_value      (rs_value),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .inst_valid    (inst_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign      (misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_instr_t;

    exp_instr_t  instr_q[$];
    logic [31:0] addr_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Stimulus knobs
    int          k_delay_min = 0, k_delay_max = 0, k_stall_pct = 0;
    bit          k_rand_rdata = 0, k_rand_sel = 0, k_rand_br = 0, k_rand_rs = 0;
    logic [31:0] k_rdata = 32'h2085_0004;
    logic [1:0]  k_sel = 2'd0;
    logic        k_br = 1'b0;
    logic [31:0] k_rs = 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [31:0] RS_MASK = 32'hFFFF_FFFC;
`else
    localparam logic [31:0] RS_MASK = 32'hFFFF_FFFF;
`endif

    // Reference model state
    logic [31:0] model_pc = RST_PC;
    logic [31:0] model_instr = 32'h0;
    bit          model_halt = 0;
    bit          mem_busy = 0;
    int          mem_wait = 0;
    int          retire_cnt = 0;
    bit          in_reset = 1;

    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur_pc, input logic [31:0] word,
                                                 input logic [1:0] sel, input logic br,
                                                 input logic [31:0] rs);
        logic [31:0] p4;
        int          imm;
        logic [31:0] r;
        p4  = cur_pc + 32'd4;
        imm = int'($signed(word[15:0]));
        case (sel)
            2'd0:    r = p4;
            2'd1:    r = br ? p4 + 32'(imm * 4) : p4;
            2'd2:    r = (p4 & 32'hF000_0000) | (32'(word[25:0]) * 32'd4);
            default: r = rs;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: event missing or unexpected", name);
    endtask

    // Memory responder and decoder emulation for one cycle, driven just after the falling edge.
    task automatic drive_now();
        logic [31:0] word, nxt;
        exp_instr_t  e;
        if (imem_req === 1'b1) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_wait = int'($urandom_range(k_delay_max, k_delay_min));
            end
            if (mem_wait == 0) begin
                word       = k_rand_rdata ? $urandom : k_rdata;
                imem_ack   = 1'b1;
                imem_rdata = word;
                e.word     = word;
                e.addr     = model_pc;
                instr_q.push_back(e);
                model_instr = word;
                mem_busy    = 0;
            end else begin
                mem_wait--;
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
            end
        end else begin
            mem_busy   = 0;
            imem_ack   = ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom;
        end
        if (inst_valid === 1'b1) begin
            stall         = (int'($urandom_range(0, 99)) < k_stall_pct);
            PC_MUX_Select = k_rand_sel ? 2'($urandom) : k_sel;
            br_taken      = k_rand_br ? 1'($urandom) : k_br;
            rs_value      = k_rand_rs ? ($urandom & RS_MASK) : k_rs;
            if (!stall) begin
                retire_cnt++;
                nxt = ref_next_pc(model_pc, model_instr, PC_MUX_Select, br_taken, rs_value);
`ifdef FETCH_MISALIGN_TRAP_EN
                if (nxt[1:0] != 2'b00) begin
                    model_halt = 1;
                end else begin
                    model_pc = nxt;
                    addr_q.push_back(nxt);
                end
`else
                nxt      = {nxt[31:2], 2'b00};
                model_pc = nxt;
                addr_q.push_back(nxt);
`endif
            end
        end else begin
            stall         = 1'($urandom);
            PC_MUX_Select = 2'($urandom);
            br_taken      = 1'($urandom);
            rs_value      = $urandom;
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            #1;
            drive_now();
        end
    endtask

    task automatic run_retires(input int n);
        int target, guard;
        target = retire_cnt + n;
        guard  = 0;
        while (retire_cnt < target && guard < 200) begin
            applyStimulus(1);
            guard++;
        end
        if (retire_cnt < target) fail_now("retire_timeout");
    endtask

    task automatic expect_fetch(input string name, input logic [31:0] addr);
        applyStimulus(1);
        checkOutput({name, "_req"}, imem_req, 1);
        checkOutput(name, imem_addr, addr);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_req"}, imem_req, 0);
        checkOutput({tag, "_valid"}, inst_valid, 0);
        checkOutput({tag, "_pc"}, pc, RST_PC);
        checkOutput({tag, "_addr"}, imem_addr, RST_PC);
        checkOutput({tag, "_instr"}, instruction, NOP_INSTR);
        checkOutput({tag, "_pc_plus4"}, pc_plus4, RST_PC + 32'd4);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput({tag, "_misalign"}, misalign, 0);
`endif
    endtask

    // Asynchronous reset mid-cycle, a stray ack around release, then the first fetch.
    task automatic do_reset();
        #2;
        rst      = 1'b1;
        in_reset = 1;
        #1;
        check_reset_outputs("async_rst");
        instr_q.delete();
        addr_q.delete();
        addr_q.push_back(RST_PC);
        model_pc   = RST_PC;
        model_halt = 0;
        mem_busy   = 0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        rst      = 1'b0;
        in_reset = 0;
        @(negedge clk);
        #1;
        checkOutput("late_ack_valid", inst_valid, 0);
        checkOutput("late_ack_instr", instruction, NOP_INSTR);
        checkOutput("post_rst_req", imem_req, 1);
        checkOutput("post_rst_addr", imem_addr, RST_PC);
        drive_now();
    endtask

    // Monitor: pops expectations whenever the DUT presents a new instruction or request.
    exp_instr_t  cur;
    logic [31:0] cur_addr;
    bit          pv, pr;
    initial begin
        pv = 0;
        pr = 0;
        cur.word = 32'h0;
        cur.addr = 32'h0;
        cur_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 || in_reset) begin
                pv = 0;
                pr = 0;
            end else begin
                if (inst_valid === 1'b1) begin
                    if (!pv) begin
                        if (instr_q.size() == 0) begin
                            fail_now("unexpected_valid");
                        end else begin
                            cur = instr_q.pop_front();
                            checkOutput("instruction", instruction, cur.word);
                            checkOutput("pc", pc, cur.addr);
                            checkOutput("pc_plus4", pc_plus4, cur.addr + 32'd4);
                        end
                    end else begin
                        checkOutput("held_instruction", instruction, cur.word);
                        checkOutput("held_pc", pc, cur.addr);
                    end
                    checkOutput("req_during_valid", imem_req, 0);
                end else if (pv && stall === 1'b1) begin
                    checkOutput("valid_dropped_in_stall", inst_valid, 1);
                end
                if (imem_req === 1'b1) begin
                    if (!pr) begin
                        if (addr_q.size() == 0) begin
                            fail_now("unexpected_request");
                        end else begin
                            cur_addr = addr_q.pop_front();
                            checkOutput("fetch_addr", imem_addr, cur_addr);
                        end
                    end else begin
                        checkOutput("held_fetch_addr", imem_addr, cur_addr);
                    end
                end
                pv = (inst_valid === 1'b1);
                pr = (imem_req === 1'b1);
            end
        end
    end

    initial begin
        #500000;
        fail_now("global_timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        int nv, cnt, g;
        rst           = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        stall         = 1'b0;
        PC_MUX_Select = 2'd0;
        br_taken      = 1'b0;
        rs_value      = 32'h0;
        addr_q.push_back(RST_PC);
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        #1;
        rst      = 1'b0;
        in_reset = 0;

        $display("[TB] sequential fetch, zero-wait memory");
        expect_fetch("seq_addr0", 32'h0);
        applyStimulus(1);
        expect_fetch("seq_addr1", 32'h4);
        applyStimulus(1);
        expect_fetch("seq_addr2", 32'h8);
        nv = 0;
        repeat (10) begin
            applyStimulus(1);
            if (inst_valid === 1'b1) nv++;
        end
        checkOutput("seq_valid_rate", nv, 5);

        $display("[TB] branch taken / not taken");
        k_sel = 2'd3; k_rs = 32'h10;
        run_retires(1);
        k_rdata = 32'h1000_0004; k_sel = 2'd1; k_br = 1'b1;
        run_retires(1);
        expect_fetch("branch_taken", 32'h24);
        k_sel = 2'd3; k_rs = 32'h10;
        run_retires(1);
        k_sel = 2'd1; k_br = 1'b0;
        run_retires(1);
        expect_fetch("branch_not_taken", 32'h14);

        $display("[TB] jump and wrap");
        k_sel = 2'd3; k_rs = 32'h4000_0000;
        run_retires(1);
        k_rdata = 32'h0800_0009; k_sel = 2'd2;
        run_retires(1);
        expect_fetch("jump", 32'h4000_0024);
        k_sel = 2'd3; k_rs = 32'hFFFF_FFFC;
        run_retires(1);
        k_sel = 2'd0;
        run_retires(1);
        expect_fetch("wrap", 32'h0);

        $display("[TB] register jump");
        k_sel = 2'd3; k_rs = 32'h100;
        run_retires(1);
        expect_fetch("jr", 32'h100);
        k_rs = 32'h102;
        run_retires(1);
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (4) begin
            applyStimulus(1);
            checkOutput("halt_misalign", misalign, 1);
            checkOutput("halt_req", imem_req, 0);
            checkOutput("halt_valid", inst_valid, 0);
        end
        do_reset();
`else
        expect_fetch("jr_misaligned", 32'h100);
`endif

        $display("[TB] stall held in VALID");
        k_sel = 2'd0; k_stall_pct = 100;
        g = 0;
        do begin
            applyStimulus(1);
            g++;
        end while (inst_valid !== 1'b1 && g < 20);
        if (inst_valid !== 1'b1) fail_now("stall_wait_valid");
        repeat (5) begin
            applyStimulus(1);
            checkOutput("stall_valid", inst_valid, 1);
            checkOutput("stall_req", imem_req, 0);
            checkOutput("stall_instr", instruction, model_instr);
            checkOutput("stall_pc", pc, model_pc);
        end
        k_stall_pct = 0;

        $display("[TB] delayed ack");
        k_delay_min = 3; k_delay_max = 3;
        run_retires(1);
        cnt = 0;
        g   = 0;
        do begin
            applyStimulus(1);
            g++;
            if (imem_req === 1'b1) cnt++;
        end while (inst_valid !== 1'b1 && g < 20);
        checkOutput("ack_wait_req_cycles", cnt, 4);

        $display("[TB] randomized traffic");
        k_delay_min = 0; k_delay_max = 3; k_stall_pct = 30;
        k_rand_rdata = 1; k_rand_sel = 1; k_rand_br = 1; k_rand_rs = 1;
        repeat (150) run_retires(1);

        $display("[TB] async reset during FETCH");
        k_rand_rdata = 0; k_rand_sel = 0; k_rand_br = 0; k_rand_rs = 0;
        k_stall_pct = 0; k_delay_min = 10; k_delay_max = 10;
        k_sel = 2'd3; k_rs = 32'h20;
        run_retires(1);
        applyStimulus(2);
        checkOutput("pre_rst_req", imem_req, 1);
        checkOutput("pre_rst_addr", imem_addr, 32'h20);
        k_delay_min = 0; k_delay_max = 0; k_sel = 2'd0;
        do_reset();
        run_retires(3);
        applyStimulus(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and requests one 32-bit instruction at a time from instruction memory over a req/ack handshake. Presents the instruction to the decoder with a valid flag, then computes the next PC from the decoder's `PC_MUX_Select`, the branch condition and the register operand. The instruction and its PC are held stable while the stage is stalled.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `XLEN`, default 32: address/data width. Only 32 is supported.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `PC_MUX_Select` in 2: next-PC source from the decoder.
  - 00: sequential.
  - 01: branch.
  - 10: jump (J/JAL).
  - 11: register (JR/JALR).
- `br_taken` in 1: branch condition; used only when select = 01.
- `rs_value` in 32: register target for select = 11.
- `stall` in 1: downstream hold; blocks retire of the current instruction.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; equals `pc`.
- `imem_ack` in 1: memory has returned `imem_rdata` this cycle.
- `imem_rdata` in 32: fetched word.
- `instruction` out 32: word to the decoder.
- `inst_valid` out 1: `instruction` is valid.
- `pc` out 32: address of `instruction`.
- `pc_plus4` out 32: `pc + 4`, used as the JAL/JALR link value.

## Operation

- States:
  - RST: asynchronous reset only.
  - FETCH: `imem_req`=1; moves to VALID on `imem_ack`.
  - VALID: `inst_valid`=1; when `stall`=0 the instruction retires and the stage returns to FETCH.
  - HALT: exists only with the macro enabled.
- Registers updated on ack: `instruction` <= `imem_rdata`.
- Registers updated on retire: `pc` <= next PC.
- Next PC, where imm = `instruction[15:0]` and p4 = `pc + 4`:
  - 00: p4.
  - 01: p4 + (sext(imm) << 2) if `br_taken`, else p4.
  - 10: {p4[31:28], `instruction[25:0]`, 2'b00}.
  - 11: `rs_value`.
- Arithmetic is modulo 2^32. PC 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Handshake rules:
  - `imem_req` stays high and `imem_addr` stays stable until `imem_ack`.
  - `imem_ack` is ignored when `imem_req`=0.
  - Only one request is outstanding at a time.
- `stall` has no effect in FETCH.
- `instruction` keeps its last value when `inst_valid`=0. The decoder's outputs must be qualified by `inst_valid`.

## Timing

- Reset values:
  - `pc` = RESET_PC.
  - `instruction` = 32'h0 (NOP).
  - `inst_valid` = 0, `imem_req` = 0, `misalign` = 0.
  - State = FETCH after the first edge with `rst`=0. `imem_req` rises in that cycle.
- Ack in cycle N gives `inst_valid`=1 and the new `instruction` in cycle N+1.
- Retire in cycle M gives the new `pc`/`imem_addr` and `imem_req`=1 in cycle M+1.
- Zero-wait memory (ack in the same cycle as req) gives 2 cycles per instruction.
- Reset mid-operation:
  - All outputs return to their reset values immediately.
  - Any outstanding request is abandoned.
  - An ack arriving after reset while `imem_req`=0 is ignored.

## Configuration

- `FETCH_MISALIGN_TRAP_EN` defined:
  - Adds output `misalign` (1 bit).
  - If the next PC has bits [1:0] != 0, the stage enters HALT instead of FETCH. In HALT, `misalign`=1, `imem_req`=0 and `inst_valid`=0.
  - HALT is left only by reset.
- Not defined:
  - No `misalign` port and no HALT state.
  - Next PC bits [1:0] are forced to 00 silently.

## Structure

- Package `fetch_pkg` holds:
  - PC_MUX_Select encodings: PCSEL_SEQ, PCSEL_BR, PCSEL_J, PCSEL_JR.
  - State encodings.
  - NOP_INSTR = 32'h0.
  - Default RESET_PC.
- One sub-module, `next_pc_calc`: purely combinational. It takes pc, instruction, select, `br_taken` and `rs_value`, and produces the next PC.

## Test plan

- Sequential fetch: reset, then zero-wait memory returns 32'h2085_0004 with select=00 and stall=0.
  - Expect `imem_addr` 0, 4, 8.
  - Expect `inst_valid` high every second cycle.
- Branch: at pc=0x10 with imm=4 and select=01.
  - `br_taken`=1: next fetch address 0x24.
  - `br_taken`=0: next fetch address 0x14.
- Jump: instruction 32'h0800_0009 at pc=0x4000_0000 with select=10.
  - Expect next `imem_addr` = 0x4000_0024.
- Register jump: select=11.
  - `rs_value`=0x100: next fetch address 0x100.
  - `rs_value`=0x102 with macro on: `misalign`=1 and `imem_req` stays 0.
  - `rs_value`=0x102 with macro off: next fetch address 0x100.
- Stall and wait states:
  - `stall` held for 5 cycles in VALID: `instruction`, `pc` and `inst_valid` are stable, and `imem_req`=0.
  - Ack delayed 3 cycles: `imem_req` and `imem_addr` are held constant until the ack.
- Asynchronous reset during FETCH at pc=0x20:
  - Outputs reset immediately.
  - A late ack is ignored.
  - The next fetch goes to RESET_PC.
